// File: rtl/jimmy_pkg.sv
// Shared Jimmy CPU definitions: opcode encodings, fetch FSM states and the
// instruction-length rule used by both the fetch assembler and decode.
package jimmy_pkg;

    localparam int JIMMY_ADDR_W = 8;
    localparam int JIMMY_DATA_W = 8;

    // Opcodes are identified by byte0[7:2].
    localparam logic [5:0] OP_LD_IMM  = 6'b100000;
    localparam logic [5:0] OP_CMP_IMM = 6'b100011;
    localparam logic [5:0] OP_INPUT   = 6'b100110;
    localparam logic [5:0] OP_BRA     = 6'b101010;
    localparam logic [5:0] OP_BHI     = 6'b101100;
    localparam logic [5:0] OP_BEQ     = 6'b101101;

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        HOLD   = 2'd2
    } fetch_state_e;

    // Only the immediate-carrying and branch opcodes occupy a second byte.
    function automatic logic is_two_byte_op(input logic [JIMMY_DATA_W-1:0] opcode);
        logic w_two;
        w_two = 1'b0;
        case (opcode[7:2])
            OP_LD_IMM, OP_CMP_IMM, OP_BRA, OP_BHI, OP_BEQ: w_two = 1'b1;
            default:                                       w_two = 1'b0;
        endcase
        return w_two;
    endfunction

endpackage

// File: rtl/jimmy_instr_length.sv
// Combinational opcode-byte -> instruction length decoder, shared by the
// fetch assembler and the decode stage.
module jimmy_instr_length
    import jimmy_pkg::*;
(
    input  logic [JIMMY_DATA_W-1:0] i_opcode,
    output logic                    o_is_two_byte
);

    assign o_is_two_byte = is_two_byte_op(i_opcode);

endmodule

// File: rtl/jimmy_fetch_unit.sv
// Jimmy instruction fetch: owns the PC, reads program memory combinationally
// and assembles 1/2-byte instructions for execute over a valid/ready handshake.
module jimmy_fetch_unit
    import jimmy_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] address_bus,
    input  logic [7:0]            data_bus,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            instr_byte0,
    output logic [7:0]            instr_byte1,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target
);

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [7:0]            r_byte0;
    logic [7:0]            r_byte1;
    logic [ADDR_WIDTH-1:0] r_instr_pc;

    logic                  w_two_byte;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    jimmy_instr_length u_instr_length (
        .i_opcode      (data_bus),
        .o_is_two_byte (w_two_byte)
    );

    // Natural-width add gives the modulo-2^N wrap from all-ones back to zero.
    assign w_pc_inc = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // An accepted handshake in HOLD behaves exactly like a fresh FETCH0.
    assign w_start = (r_state == FETCH0) || ((r_state == HOLD) && instr_ready);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH0;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_byte0    <= 8'h00;
            r_byte1    <= 8'h00;
            r_instr_pc <= '0;
        end else if (branch_taken) begin
            // Redirect wins over everything; a held instruction seen with
            // ready this cycle is already consumed by execute.
            r_state <= FETCH0;
            r_pc    <= branch_target;
            r_valid <= 1'b0;
        end else if (w_start) begin
            r_byte0    <= data_bus;
            r_instr_pc <= r_pc;
            r_pc       <= w_pc_inc;
            if (w_two_byte) begin
                r_valid <= 1'b0;
                r_state <= FETCH1;
            end else begin
                r_byte1 <= 8'h00;
                r_valid <= 1'b1;
                r_state <= HOLD;
            end
        end else if (r_state == FETCH1) begin
            r_byte1 <= data_bus;
            r_pc    <= w_pc_inc;
            r_valid <= 1'b1;
            r_state <= HOLD;
        end else if (r_state != HOLD) begin
            r_valid <= 1'b0;
            r_state <= FETCH0;
        end
    end

    assign address_bus = r_pc;
    assign instr_valid = r_valid;
    assign instr_byte0 = r_byte0;
    assign instr_byte1 = r_byte1;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_jimmy_fetch_unit.sv
// Directed bench for jimmy_fetch_unit: scoreboard queues checked by monitors
// on accepted handshakes, plus direct timing checks from the driver.
module tb_jimmy_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT0: RESET_PC = 00
    logic       reset0, ready0, br0, valid0;
    logic [7:0] tgt0, addr0, data0, b0_0, b1_0, ipc0;
    // DUT1: RESET_PC = FF
    logic       reset1, ready1, br1, valid1;
    logic [7:0] tgt1, addr1, data1, b0_1, b1_1, ipc1;

    logic [7:0] rom0 [0:255];
    logic [7:0] rom1 [0:255];
    assign data0 = rom0[addr0];
    assign data1 = rom1[addr1];

    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q0 [$];
    logic [23:0] exp_q1 [$];

    jimmy_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) u_dut0 (
        .clk(clk), .reset(reset0), .address_bus(addr0), .data_bus(data0),
        .instr_valid(valid0), .instr_ready(ready0), .instr_byte0(b0_0),
        .instr_byte1(b1_0), .instr_pc(ipc0), .branch_taken(br0),
        .branch_target(tgt0)
    );

    jimmy_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'hFF)) u_dut1 (
        .clk(clk), .reset(reset1), .address_bus(addr1), .data_bus(data1),
        .instr_valid(valid1), .instr_ready(ready1), .instr_byte0(b0_1),
        .instr_byte1(b1_1), .instr_pc(ipc1), .branch_taken(br1),
        .branch_target(tgt1)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: an instruction is consumed on the edge following valid && ready.
    always @(negedge clk) begin
        if (!reset0 && valid0 && ready0) begin
            if (exp_q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0_accept: got %h%h%h expected none", b0_0, b1_0, ipc0);
            end else begin
                check("dut0_accept", 40'({b0_0, b1_0, ipc0}), 40'(exp_q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset1 && valid1 && ready1) begin
            if (exp_q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_accept: got %h%h%h expected none", b0_1, b1_1, ipc1);
            end else begin
                check("dut1_accept", 40'({b0_1, b1_1, ipc1}), 40'(exp_q1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom0[i] = 8'h00;
            rom1[i] = 8'h00;
        end
        rom0[0] = 8'h98; rom0[1] = 8'h99; rom0[2] = 8'h01; rom0[3] = 8'h9C;
        rom0[4] = 8'hA8; rom0[5] = 8'h00; rom0[6] = 8'h98; rom0[7] = 8'h99;
        rom1[8'hFF] = 8'h80; rom1[0] = 8'h2A; rom1[1] = 8'h98;

        reset0 = 1'b1; ready0 = 1'b0; br0 = 1'b0; tgt0 = 8'h00;
        reset1 = 1'b1; ready1 = 1'b0; br1 = 1'b0; tgt1 = 8'h00;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 40'(valid0), 40'(0));
        check("rst_outs",  40'({b0_0, b1_0, ipc0}), 40'(0));
        check("rst_addr0", 40'(addr0), 40'(8'h00));
        check("rst_addr1", 40'(addr1), 40'(8'hFF));

        // First instruction: one edge after reset release
        reset0 = 1'b0;
        check("rel_addr", 40'(addr0), 40'(8'h00));
        exp_q0.push_back({8'h98, 8'h00, 8'h00});
        tick();
        check("first_instr", 40'({valid0, b0_0, b1_0, ipc0, addr0}),
              {1'b1, 8'h98, 8'h00, 8'h00, 8'h01});

        // Streaming 1-byte instructions at one per cycle
        exp_q0.push_back({8'h99, 8'h00, 8'h01});
        exp_q0.push_back({8'h01, 8'h00, 8'h02});
        exp_q0.push_back({8'h9C, 8'h00, 8'h03});
        exp_q0.push_back({8'hA8, 8'h00, 8'h04});
        ready0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("stream_valid", 40'(valid0), 40'(1));
            check("stream_pc", 40'(ipc0), 40'(i));
        end

        // Two-byte BRA: one bubble cycle
        tick();
        check("bubble", 40'({valid0, addr0}), 40'({1'b0, 8'h05}));
        ready0 = 1'b0;
        tick();
        check("two_byte", 40'({valid0, b0_0, b1_0, ipc0, addr0}),
              {1'b1, 8'hA8, 8'h00, 8'h04, 8'h06});

        // Backpressure: everything frozen
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", 40'({valid0, b0_0, b1_0, ipc0, addr0}),
                  {1'b1, 8'hA8, 8'h00, 8'h04, 8'h06});
        end

        // Resume at next pc
        exp_q0.push_back({8'h98, 8'h00, 8'h06});
        ready0 = 1'b1;
        tick();
        check("resume", 40'({valid0, b0_0, ipc0, addr0}),
              40'({1'b1, 8'h98, 8'h06, 8'h07}));

        // Redirect coinciding with accept of the held instruction
        br0 = 1'b1; tgt0 = 8'h00;
        tick();
        br0 = 1'b0; ready0 = 1'b0;
        check("redir_bubble", 40'({valid0, addr0}), 40'({1'b0, 8'h00}));
        exp_q0.push_back({8'h98, 8'h00, 8'h00});
        tick();
        check("redir_first", 40'({valid0, b0_0, ipc0, addr0}),
              40'({1'b1, 8'h98, 8'h00, 8'h01}));
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        check("post_redir", 40'({valid0, b0_0, ipc0}), 40'({1'b1, 8'h99, 8'h01}));

        // Async reset mid-HOLD, no clock edge in between
        #2 reset0 = 1'b1;
        #1;
        check("async_rst_hold", 40'({valid0, b0_0, addr0}), 40'({1'b0, 8'h00, 8'h00}));
        tick();

        // Redirect with valid=0 (FETCH0), then redirect mid-FETCH1
        reset0 = 1'b0; br0 = 1'b1; tgt0 = 8'h04;
        tick();
        br0 = 1'b0;
        check("redir_idle", 40'({valid0, addr0}), 40'({1'b0, 8'h04}));
        tick();
        check("fetch1_entry", 40'({valid0, addr0}), 40'({1'b0, 8'h05}));
        br0 = 1'b1; tgt0 = 8'h02;
        tick();
        br0 = 1'b0;
        check("redir_fetch1", 40'({valid0, addr0}), 40'({1'b0, 8'h02}));
        exp_q0.push_back({8'h01, 8'h00, 8'h02});
        tick();
        check("redir_discard", 40'({valid0, b0_0, b1_0, ipc0}),
              40'({1'b1, 8'h01, 8'h00, 8'h02}));
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;

        // DUT1: wrap at FF with a two-byte LD_IMM
        reset1 = 1'b0;
        tick();
        check("wrap_fetch1", 40'({valid1, addr1}), 40'({1'b0, 8'h00}));
        exp_q1.push_back({8'h80, 8'h2A, 8'hFF});
        tick();
        check("wrap_instr", 40'({valid1, b0_1, b1_1, ipc1, addr1}),
              {1'b1, 8'h80, 8'h2A, 8'hFF, 8'h01});
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        check("wrap_next", 40'({valid1, b0_1, ipc1}), 40'({1'b1, 8'h98, 8'h01}));

        // Async reset mid-FETCH1
        reset1 = 1'b1;
        tick();
        reset1 = 1'b0;
        tick();
        check("pre_rst_fetch1", 40'({valid1, addr1}), 40'({1'b0, 8'h00}));
        #2 reset1 = 1'b1;
        #1;
        check("async_rst_fetch1", 40'({valid1, b0_1, addr1}), 40'({1'b0, 8'h00, 8'hFF}));
        tick();
        reset1 = 1'b0;
        repeat (2) tick();
        check("rst_refetch", 40'({valid1, b0_1, b1_1, ipc1}),
              40'({1'b1, 8'h80, 8'h2A, 8'hFF}));

        tick();
        check("dut0_drained", 40'(exp_q0.size()), 40'(0));
        check("dut1_drained", 40'(exp_q1.size()), 40'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
